// File: rtl/scan_master.sv
// scan_master: drives an N-bit scan chain, shifting a pattern in and the captured
// parallel data out in one transaction of exactly N shift cycles.
module scan_master #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:N-1] wdata,
    output logic         busy,
    output logic         done,
    output logic [0:N-1] rdata,
    output logic         scan_test,
    output logic         scan_in,
    input  logic         scan_out
);
    localparam int KW = $clog2(N);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state_q, state_d;
    logic [KW-1:0] k_q, k_d, idx;
    logic [0:N-1] wreg_q, wreg_d, rdata_q, rdata_d;
    logic shifting, last;
    assign shifting = state_q == SHIFT;
    assign last = k_q == KW'(N - 1);
    // Bit N-1-k is both the next pattern bit to send and the chain bit arriving now.
    assign idx = KW'(N - 1) - k_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            wreg_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wreg_q  <= wreg_d;
            rdata_q <= rdata_d;
        end
    end
    always_comb begin
        state_d = state_q == IDLE ? (start ? SHIFT : IDLE) :
                  shifting        ? (last ? DONE : SHIFT) : IDLE;
        wreg_d  = (state_q == IDLE && start) ? wdata : wreg_q;
        k_d     = shifting ? k_q + KW'(1) : '0;
        rdata_d = rdata_q;
        if (shifting) rdata_d[idx] = scan_out;
    end
    assign busy      = shifting;
    assign scan_test = shifting;
    assign scan_in   = shifting & wreg_q[idx];
    assign done      = state_q == DONE;
    assign rdata     = rdata_q;
endmodule

// File: tb/tb_scan_master.sv
// tb_scan_master: table, hand-written and random transactions against a behavioural
// scan-chain target and reference expectations derived from the transaction rules.
module tb_scan_master;
    localparam int N = 4;
    logic clk, rst_n, start, busy, done, scan_test, scan_in, scan_out;
    logic [0:N-1] wdata, rdata, pdata, tgt;
    int checks = 0, errors = 0;

    scan_master #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .wdata(wdata), .busy(busy),
        .done(done), .rdata(rdata), .scan_test(scan_test), .scan_in(scan_in),
        .scan_out(scan_out)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Target chain: shift toward N-1 in test mode, parallel load otherwise.
    always @(posedge clk) tgt <= scan_test ? {scan_in, tgt[0:N-2]} : pdata;
    assign scan_out = tgt[N-1];

    typedef struct {
        logic [0:N-1] wd;
        logic [0:N-1] pd;
        logic [0:N-1] exp_rdata;
        logic [0:N-1] exp_tgt;
    } vec_t;
    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at a negedge in IDLE after the done cycle.
    task automatic run_txn(input logic [0:N-1] wd, input logic [0:N-1] pd,
                           input logic [0:N-1] exp_r, input logic [0:N-1] exp_t,
                           input bit chg, input string tag);
        logic [0:N-1] sin_seq, rev;
        int busy_n, done_n;
        start = 1; wdata = wd; pdata = pd;
        @(negedge clk);
        start = 0;
        if (chg) wdata = ~wd;
        busy_n = 0; done_n = 0;
        for (int i = 0; i < N; i++) begin
            sin_seq[i] = scan_in;
            busy_n += int'(busy && scan_test);
            done_n += int'(done);
            @(negedge clk);
        end
        for (int i = 0; i < N; i++) rev[i] = wd[N-1-i];
        check({tag, "_sin_seq"}, 32'(sin_seq), 32'(rev));
        check({tag, "_busy_cycles"}, busy_n, N);
        check({tag, "_early_done"}, done_n, 0);
        check({tag, "_done_cycle_ctl"}, {28'b0, done, busy, scan_test, scan_in}, 32'b1000);
        check({tag, "_rdata"}, 32'(rdata), 32'(exp_r));
        check({tag, "_target_out"}, 32'(tgt), 32'(exp_t));
        @(negedge clk);
        check({tag, "_idle_after"}, {30'b0, done, busy}, 0);
        check({tag, "_rdata_held"}, 32'(rdata), 32'(exp_r));
    endtask

    initial begin
        int last_done, busy_since, dones;
        logic [0:N-1] wd, pd;
        vecs[0] = '{4'b1010, 4'b0011, 4'b0011, 4'b1010};
        vecs[1] = '{4'b0000, 4'b1111, 4'b1111, 4'b0000};
        vecs[2] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111};
        rst_n = 0; start = 0; wdata = '0; pdata = '0;
        #2;
        check("reset_outputs", {23'b0, busy, done, scan_test, scan_in, 1'b0, rdata}, 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        check("idle_outputs", {28'b0, busy, done, scan_test, scan_in}, 0);

        foreach (vecs[v])
            run_txn(vecs[v].wd, vecs[v].pd, vecs[v].exp_rdata, vecs[v].exp_tgt, 0, $sformatf("vec%0d", v));

        run_txn(4'b1010, 4'b0011, 4'b0011, 4'b1010, 1, "stability");

        pdata = 4'b1100;
        repeat (3) @(negedge clk);
        check("rdata_hold_idle", 32'(rdata), 32'(4'b0011));

        // start held high: each transaction accepted only from IDLE
        start = 1; wdata = 4'b0110; pdata = 4'b1001;
        last_done = -1; busy_since = 0; dones = 0;
        for (int c = 0; c < 3 * (N + 2); c++) begin
            @(negedge clk);
            busy_since += int'(busy);
            if (done) begin
                if (last_done < 0) check("first_done_latency", c, N);
                else begin
                    check("done_spacing", c - last_done, N + 2);
                    check("busy_per_txn", busy_since, N);
                end
                check("held_start_rdata", 32'(rdata), 32'(4'b1001));
                last_done = c; busy_since = 0; dones++;
            end
            if (c == 3 * (N + 2) - 1) start = 0;
        end
        check("held_start_dones", dones, 3);
        @(negedge clk);
        check("held_start_idle", {30'b0, busy, done}, 0);

        // reset in the third shift cycle aborts the transaction
        start = 1; wdata = 4'b1010; pdata = 4'b0110;
        @(negedge clk); start = 0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_shift", 32'(busy), 1);
        rst_n = 0;
        #1;
        check("abort_outputs", {23'b0, busy, done, scan_test, scan_in, 1'b0, rdata}, 0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            dones += int'(done);
        end
        rst_n = 1;
        repeat (2) begin
            @(negedge clk);
            dones += int'(done);
        end
        check("abort_no_done", dones, 0);
        run_txn(4'b1010, 4'b0011, 4'b0011, 4'b1010, 0, "post_abort");

        for (int r = 0; r < 16; r++) begin
            wd = N'($urandom);
            pd = N'($urandom);
            run_txn(wd, pd, pd, wd, bit'($urandom_range(0, 1)), $sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
